// File: rtl/icache_pkg.sv
// Instruction-cache shared definitions: refill FSM encoding and line geometry,
// used by the refill engine and by the cache itself.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } refill_state_e;

  localparam int LINE_BYTES   = 16;
  localparam int LINE_OFF_W   = 4;
  localparam int WORD_OFF_LSB = 2;
  localparam int LINE_W       = 128;

endpackage

// File: rtl/icache_refill_ctrl_line_buf.sv
// Line assembly register for the refill engine: one bus word per slot,
// each slot written only when the refill counter selects it.
module refill_line_buf #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int SLOT_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [SLOT_W-1:0]         i_slot,
  input  logic [WORD_W-1:0]         i_wdata,
  output logic [WORD_W*WORDS-1:0]   o_line
);

  localparam int LINE_BITS = WORD_W * WORDS;

  logic [LINE_BITS-1:0] r_line;
  logic [WORDS-1:0]     w_slot_we;

  // Decode the selected slot into a one-hot write enable.
  always_comb begin
    w_slot_we = {WORDS{1'b0}};
    for (int k = 0; k < WORDS; k++) begin
      if (i_we && (i_slot == SLOT_W'(k))) begin
        w_slot_we[k] = 1'b1;
      end else begin
        w_slot_we[k] = 1'b0;
      end
    end
  end

  // Slots keep the previous line until the next refill overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= {LINE_BITS{1'b0}};
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        if (w_slot_we[k]) begin
          r_line[k*WORD_W +: WORD_W] <= i_wdata;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill engine: fetches one line as sequential word reads
// on the instruction memory bus and returns it with a one-cycle ready pulse.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid_i,
  input  logic [ADDR_W-1:0]                req_addr_i,
  output logic                             mem_ready_o,
  output logic [WORD_W*WORDS_PER_LINE-1:0] mem_data_o,
  output logic                             busy_o,
  output logic                             bus_req_o,
  output logic [ADDR_W-1:0]                bus_addr_o,
  input  logic                             bus_gnt_i,
  input  logic                             bus_rvalid_i,
  input  logic [WORD_W-1:0]                bus_rdata_i
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = CNT_W + WORD_OFF_LSB;
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS_PER_LINE - 1);

  refill_state_e      r_state;
  refill_state_e      w_state_nxt;
  logic [TAG_W-1:0]   r_base;
  logic [TAG_W-1:0]   w_base_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               r_bus_req;
  logic               r_mem_ready;
  logic               r_busy;
  logic [ADDR_W-1:0]  r_bus_addr;
  logic               w_bus_req_nxt;
  logic               w_mem_ready_nxt;
  logic               w_busy_nxt;
  logic [ADDR_W-1:0]  w_bus_addr_nxt;

  logic               w_word_we;
  logic               w_unused_offset;

  // The line offset of the request is discarded; only the line base is kept.
  assign w_unused_offset = ^req_addr_i[OFF_W-1:0];

  // State, line base and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_base  <= {TAG_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: requests are only accepted in IDLE; rvalid only counts in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          w_state_nxt = REQ;
          w_base_nxt  = req_addr_i[ADDR_W-1:OFF_W];
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          if (r_cnt == LAST_SLOT) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = REQ;
            w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    w_bus_req_nxt   = (w_state_nxt == REQ);
    w_mem_ready_nxt = (w_state_nxt == DONE);
    w_busy_nxt      = (w_state_nxt != IDLE);
    // Counter occupies the word-offset bits, so no carry reaches the tag.
    if (w_state_nxt == REQ) begin
      w_bus_addr_nxt = {w_base_nxt, w_cnt_nxt, {WORD_OFF_LSB{1'b0}}};
    end else begin
      w_bus_addr_nxt = r_bus_addr;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req   <= 1'b0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_bus_addr  <= {ADDR_W{1'b0}};
    end else begin
      r_bus_req   <= w_bus_req_nxt;
      r_mem_ready <= w_mem_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
    end
  end

  assign w_word_we = (r_state == WAIT) && bus_rvalid_i;

  refill_line_buf #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS_PER_LINE),
    .SLOT_W (CNT_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_word_we),
    .i_slot  (r_cnt),
    .i_wdata (bus_rdata_i),
    .o_line  (mem_data_o)
  );

  assign bus_req_o   = r_bus_req;
  assign mem_ready_o = r_mem_ready;
  assign busy_o      = r_busy;
  assign bus_addr_o  = r_bus_addr;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: schedule-based refill model,
// per-cycle compare process, directed cases plus randomized refills.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid_i;
  logic [31:0]  req_addr_i;
  logic         mem_ready_o;
  logic [127:0] mem_data_o;
  logic         busy_o;
  logic         bus_req_o;
  logic [31:0]  bus_addr_o;
  logic         bus_gnt_i;
  logic         bus_rvalid_i;
  logic [31:0]  bus_rdata_i;

  icache_refill_ctrl #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .mem_ready_o  (mem_ready_o),
    .mem_data_o   (mem_data_o),
    .busy_o       (busy_o),
    .bus_req_o    (bus_req_o),
    .bus_addr_o   (bus_addr_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle, set by the stimulus just after the edge.
  logic         e_busy, e_req, e_ready, e_addr_chk;
  logic [31:0]  e_addr;
  logic [127:0] e_line;
  bit           chk_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc, last_ready_cyc, n_ready = 0;
  logic [127:0] ready_line;
  logic [31:0]  gnt_log[$];

  int          g_dly[4];
  int          v_dly[4];
  logic [31:0] w_data[4];
  int          extra_req_t = -1;
  logic [31:0] extra_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_o", 128'(busy_o), 128'(e_busy));
      chk("bus_req_o", 128'(bus_req_o), 128'(e_req));
      chk("mem_ready_o", 128'(mem_ready_o), 128'(e_ready));
      chk("mem_data_o", mem_data_o, e_line);
      if (e_addr_chk) chk("bus_addr_o", 128'(bus_addr_o), 128'(e_addr));
    end
    if (mem_ready_o === 1'b1) begin
      n_ready++;
      last_ready_cyc = cyc;
      ready_line = mem_data_o;
    end
    if (bus_req_o === 1'b1 && bus_gnt_i === 1'b1) gnt_log.push_back(bus_addr_o);
  end

  // One refill driven from a precomputed schedule of grant/data cycles.
  task automatic refill(input logic [31:0] addr, input bit noise, input int rst_at);
    int s[4], gc[4], dc[4];
    int r;
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    s[0] = 1;
    for (int k = 0; k < 4; k++) begin
      gc[k] = s[k] + g_dly[k];
      dc[k] = gc[k] + 1 + v_dly[k];
      if (k < 3) s[k+1] = dc[k] + 1;
    end
    r = dc[3] + 1;
    for (int t = 0; t <= r; t++) begin
      @(posedge clk); #1;
      if (t == 0) req_cyc = cyc;
      if (t == rst_at) begin
        rst_n = 1'b0;
        e_busy = 1'b0; e_req = 1'b0; e_ready = 1'b0;
        e_addr_chk = 1'b1; e_addr = 32'h0; e_line = 128'h0;
        req_valid_i = 1'b0; bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = $urandom;
        return;
      end
      for (int k = 0; k < 4; k++)
        if (t == dc[k] + 1) e_line[32*k +: 32] = w_data[k];
      e_busy = (t >= 1);
      e_ready = (t == r);
      e_req = 1'b0;
      e_addr_chk = 1'b0;
      for (int k = 0; k < 4; k++)
        if (t >= s[k] && t <= gc[k]) begin
          e_req = 1'b1; e_addr_chk = 1'b1; e_addr = base + 32'(4*k);
        end
      req_valid_i = (t == 0) ? 1'b1 : (noise && ($urandom_range(0, 3) == 0));
      req_addr_i = (t == 0) ? addr : $urandom;
      if (t == extra_req_t) begin
        req_valid_i = 1'b1; req_addr_i = extra_addr;
      end
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (t == gc[k]) bus_gnt_i = 1'b1;
        if (t == dc[k]) begin bus_rvalid_i = 1'b1; bus_rdata_i = w_data[k]; end
        if (noise && t >= s[k] && t <= gc[k]) bus_rvalid_i = 1'($urandom_range(0, 1));
        if (noise && t > gc[k] && t < dc[k]) bus_gnt_i = 1'($urandom_range(0, 1));
      end
      if (noise && (t == r || t == 0)) begin
        bus_gnt_i = 1'($urandom_range(0, 1)); bus_rvalid_i = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic idle(input int n, input bit rv_force);
    repeat (n) begin
      @(posedge clk); #1;
      e_busy = 1'b0; e_req = 1'b0; e_ready = 1'b0; e_addr_chk = 1'b0;
      req_valid_i = 1'b0; req_addr_i = $urandom;
      bus_gnt_i = 1'($urandom_range(0, 1));
      bus_rvalid_i = rv_force ? 1'b1 : 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
    end
  endtask

  task automatic zero_delays();
    for (int k = 0; k < 4; k++) begin g_dly[k] = 0; v_dly[k] = 0; end
  endtask

  task automatic seq_data();
    w_data[0] = 32'h11111111; w_data[1] = 32'h22222222;
    w_data[2] = 32'h33333333; w_data[3] = 32'h44444444;
  endtask

  initial begin
    int nr0;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_addr_i = 32'h0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    e_busy = 1'b0; e_req = 1'b0; e_ready = 1'b0;
    e_addr_chk = 1'b1; e_addr = 32'h0; e_line = 128'h0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b0);

    // Zero-wait refill.
    zero_delays(); seq_data();
    gnt_log.delete(); nr0 = n_ready;
    refill(32'h0000_1238, 1'b0, -1);
    idle(2, 1'b0);
    chk("zw_latency", 128'(last_ready_cyc - req_cyc), 128'd9);
    chk("zw_line", ready_line, 128'h44444444_33333333_22222222_11111111);
    chk("zw_addr0", 128'(gnt_log[0]), 128'h1230);
    chk("zw_addr1", 128'(gnt_log[1]), 128'h1234);
    chk("zw_addr2", 128'(gnt_log[2]), 128'h1238);
    chk("zw_addr3", 128'(gnt_log[3]), 128'h123C);
    chk("zw_pulses", 128'(n_ready - nr0), 128'd1);

    // Wait states: grant late on word 1, data late on word 3.
    zero_delays(); g_dly[1] = 2; v_dly[3] = 3;
    for (int k = 0; k < 4; k++) w_data[k] = $urandom;
    refill(32'h0000_1238, 1'b0, -1);
    idle(1, 1'b0);
    chk("ws_latency", 128'(last_ready_cyc - req_cyc), 128'd14);
    chk("ws_line", ready_line, {w_data[3], w_data[2], w_data[1], w_data[0]});

    // Request while busy is dropped.
    zero_delays(); seq_data();
    gnt_log.delete(); nr0 = n_ready;
    extra_req_t = 5; extra_addr = 32'h0000_5000;
    refill(32'h0000_1230, 1'b0, -1);
    extra_req_t = -1;
    idle(12, 1'b0);
    chk("busy_req_count", 128'(gnt_log.size()), 128'd4);
    chk("busy_req_addr2", 128'(gnt_log[2]), 128'h1238);
    chk("busy_req_pulses", 128'(n_ready - nr0), 128'd1);

    // Asynchronous reset with two words captured, then a stale rvalid.
    zero_delays(); for (int k = 0; k < 4; k++) w_data[k] = $urandom;
    refill(32'h0000_1230, 1'b0, 5);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3, 1'b1);
    zero_delays(); seq_data(); gnt_log.delete();
    refill(32'h0000_2000, 1'b0, -1);
    idle(1, 1'b0);
    chk("post_rst_addr0", 128'(gnt_log[0]), 128'h2000);
    chk("post_rst_addr3", 128'(gnt_log[3]), 128'h200C);
    chk("post_rst_line", ready_line, 128'h44444444_33333333_22222222_11111111);

    // Back-to-back: previous line held while the new word 0 is slow.
    zero_delays(); seq_data();
    refill(32'h0000_3000, 1'b0, -1);
    g_dly[0] = 2; v_dly[0] = 2;
    for (int k = 0; k < 4; k++) w_data[k] = 32'hA0000000 + 32'(k);
    refill(32'h0000_4010, 1'b0, -1);
    idle(1, 1'b0);
    chk("b2b_line", ready_line, 128'hA0000003_A0000002_A0000001_A0000000);

    // Top of the address space: no wrap past the line.
    zero_delays(); seq_data(); gnt_log.delete();
    refill(32'hFFFF_FFF4, 1'b0, -1);
    idle(1, 1'b0);
    chk("top_addr0", 128'(gnt_log[0]), 128'hFFFFFFF0);
    chk("top_addr3", 128'(gnt_log[3]), 128'hFFFFFFFC);

    // Randomized refills with bus noise, illegal requests and varied gaps.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) begin
        g_dly[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        v_dly[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        w_data[k] = $urandom;
      end
      refill($urandom, 1'b1, -1);
      idle(int'($urandom_range(0, 3)), 1'b0);
    end

    idle(2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
